// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and defaults for the GCD requester
package gcd_pkg;
  localparam int GCD_W = 8;
  localparam int TIMEOUT_DEF = 2048;
  typedef enum logic [2:0] {SYNC, IDLE, CLR, START, LOAD_B, WAIT, RESP} state_t;
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_FAIL = 1'b1;
endpackage

// File: rtl/gcd_timer.sv
// gcd_timer: saturating cycle counter with clear/enable and terminal count
module gcd_timer
  import gcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt;
  // count enabled cycles, holding at TIMEOUT_CYCLES instead of wrapping
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en && cnt != TW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
  assign tc = cnt >= TW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/gcd_requester.sv
// gcd_requester: drives the GCD engine start/done protocol from a valid/ready request port
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int W = GCD_W,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_gcd,
  output logic         rsp_err,
  output logic         gcd_start,
  output logic [W-1:0] gcd_data,
  input  logic         gcd_ld_a,
  input  logic         gcd_ld_b,
  input  logic         gcd_done,
  input  logic [W-1:0] gcd_result,
  output logic         busy
);
  state_t state;
  logic [W-1:0] a_q, b_q;
  logic done_q, flush_q, tmr_clr, tmr_en, tmr_tc;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign tmr_en = state inside {SYNC, START, LOAD_B, WAIT};
  assign tmr_clr = state inside {IDLE, CLR, RESP} || (state == LOAD_B && gcd_ld_b);
  gcd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(tmr_clr),
    .en(tmr_en),
    .tc(tmr_tc)
  );
  // request/engine handshake sequencer with registered outputs
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= SYNC;
      a_q <= '0;
      b_q <= '0;
      done_q <= 1'b0;
      flush_q <= 1'b0;
      gcd_start <= 1'b0;
      gcd_data <= '0;
      rsp_valid <= 1'b0;
      rsp_gcd <= '0;
      rsp_err <= 1'b0;
    end else begin
      done_q <= gcd_done;
      case (state)
        SYNC: if (tmr_tc) state <= IDLE;
        IDLE:
          if (req_valid) begin
            a_q <= req_a;
            b_q <= req_b;
            if (req_a == '0 || req_b == '0) begin
              state <= RESP;
              rsp_valid <= 1'b1;
              rsp_gcd <= '0;
              rsp_err <= ERR_FAIL;
              flush_q <= 1'b0;
            end else state <= CLR;
          end
        CLR:
          if (!gcd_done) begin
            state <= START;
            gcd_start <= 1'b1;
            gcd_data <= a_q;
          end
        START:
          if (gcd_ld_a) begin
            state <= LOAD_B;
            gcd_start <= 1'b0;
            gcd_data <= b_q;
          end else if (tmr_tc) begin
            state <= RESP;
            gcd_start <= 1'b0;
            gcd_data <= '0;
            rsp_valid <= 1'b1;
            rsp_gcd <= '0;
            rsp_err <= ERR_FAIL;
            flush_q <= 1'b1;
          end
        LOAD_B:
          if (gcd_ld_b) state <= WAIT;
          else if (tmr_tc) begin
            state <= RESP;
            gcd_data <= '0;
            rsp_valid <= 1'b1;
            rsp_gcd <= '0;
            rsp_err <= ERR_FAIL;
            flush_q <= 1'b1;
          end
        WAIT:
          if (gcd_done && !done_q) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_gcd <= gcd_result;
            rsp_err <= ERR_NONE;
            flush_q <= 1'b0;
          end else if (tmr_tc) begin
            state <= RESP;
            gcd_data <= '0;
            rsp_valid <= 1'b1;
            rsp_gcd <= '0;
            rsp_err <= ERR_FAIL;
            flush_q <= 1'b1;
          end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= flush_q ? SYNC : IDLE;
          end
        default: state <= SYNC;
      endcase
    end
endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: directed scoreboard bench with a behavioural GCD engine
module tb_gcd_requester;
  localparam int W = 8;
  localparam int T = 32;
  localparam logic [2:0] E_IDLE = 3'd0, E_LA = 3'd1, E_LB = 3'd2, E_RUN = 3'd3, E_DONE = 3'd4;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic req_ready, rsp_valid, rsp_err, gcd_start, gcd_ld_a, gcd_ld_b, gcd_done, busy;
  logic [W-1:0] rsp_gcd, gcd_data, gcd_result;
  logic hang = 1'b0;
  logic [2:0] es = E_IDLE;
  logic [W-1:0] ea = '0, eb = '0, eres = '0;
  logic [3:0] dcnt = '0;
  int n_checks = 0, n_pass = 0;
  int start_rises = 0, bad_start = 0;
  logic start_q = 1'b0;
  logic [W-1:0] lda_val = '0, ldb_val = '0;
  logic [W:0] sb[$];

  gcd_requester #(.W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
    .gcd_start(gcd_start), .gcd_data(gcd_data), .gcd_ld_a(gcd_ld_a), .gcd_ld_b(gcd_ld_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // engine: loads A then B, subtractive Euclid, sticky done cleared after 8 start-low cycles
  always @(posedge clk)
    case (es)
      E_IDLE: if (gcd_start) es <= E_LA;
      E_LA: begin ea <= gcd_data; es <= E_LB; end
      E_LB: begin eb <= gcd_data; es <= E_RUN; end
      E_RUN:
        if (!hang) begin
          if (ea == eb) begin eres <= ea; es <= E_DONE; dcnt <= '0; end
          else if (ea > eb) ea <= ea - eb;
          else eb <= eb - ea;
        end
      E_DONE: if (!gcd_start) begin if (dcnt == 4'd7) es <= E_IDLE; dcnt <= dcnt + 1'b1; end
      default: es <= E_IDLE;
    endcase
  assign gcd_ld_a = es == E_LA;
  assign gcd_ld_b = es == E_LB;
  assign gcd_done = es == E_DONE;
  assign gcd_result = eres;

  // bus observer
  always @(posedge clk) begin
    start_q <= gcd_start;
    if (gcd_start && !start_q) start_rises <= start_rises + 1;
    if (gcd_start && gcd_done) bad_start <= bad_start + 1;
    if (gcd_ld_a) lda_val <= gcd_data;
    if (gcd_ld_b) ldb_val <= gcd_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    sb.push_back(exp);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input int hold, output int waited);
    logic [W:0] exp;
    int bad;
    waited = 0;
    while (!rsp_valid && waited < 300) begin @(negedge clk); waited++; end
    chk({tag, "_valid"}, rsp_valid, 1);
    if (rsp_valid) begin
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = '1;
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!rsp_valid || req_ready || {rsp_err, rsp_gcd} !== exp) bad++;
      end
      if (hold > 0) chk({tag, "_hold"}, bad, 0);
      chk({tag, "_gcd"}, rsp_gcd, exp[W-1:0]);
      chk({tag, "_err"}, rsp_err, exp[W]);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_drop"}, rsp_valid, 0);
    end
  endtask

  initial begin
    int n, w, s0, stale;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_gcd", rsp_gcd, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_start", gcd_start, 0);
    chk("rst_data", gcd_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    rst_n = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("sync_len", n, T);
    chk("idle_busy", busy, 0);
    send(8'd48, 8'd18, {1'b0, 8'd6});
    get_rsp("g48_18", 0, w);
    chk("bus_a", lda_val, 48);
    chk("bus_b", ldb_val, 18);
    send(8'd7, 8'd7, {1'b0, 8'd7});
    get_rsp("g7_7", 0, w);
    chk("done_still_high", gcd_done, 1);
    send(8'd9, 8'd6, {1'b0, 8'd3});
    get_rsp("g9_6", 0, w);
    chk("start_vs_done", bad_start, 0);
    s0 = start_rises;
    send(8'd0, 8'd5, {1'b1, 8'd0});
    get_rsp("zero", 0, w);
    chk("zero_latency", w <= 1, 1);
    chk("zero_no_start", start_rises, s0);
    send(8'd100, 8'd75, {1'b0, 8'd25});
    get_rsp("hold", 10, w);
    hang = 1'b1;
    send(8'd12, 8'd8, {1'b1, 8'd0});
    n = 0;
    while (!gcd_ld_b && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("timeout_len", n, T);
    get_rsp("timeout", 0, w);
    hang = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("flush_len", n, T);
    send(8'd60, 8'd45, {1'b0, 8'd15});
    n = 0;
    while (!gcd_ld_b && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("wait_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_start", gcd_start, 0);
    chk("mid_rst_data", gcd_data, 0);
    chk("mid_rst_gcd", rsp_gcd, 0);
    chk("mid_rst_err", rsp_err, 0);
    chk("mid_rst_ready", req_ready, 0);
    sb.delete();
    n = 0;
    stale = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; if (rsp_valid) stale++; end
    chk("no_stale_rsp", stale, 0);
    send(8'd21, 8'd14, {1'b0, 8'd7});
    get_rsp("g21_14", 0, w);
    chk("final_start_vs_done", bad_start, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
